// File: rtl/spi_master_xcvr.sv
// Full-duplex SPI master: configurable word width, all four CPOL/CPHA modes,
// programmable SCLK divider, chip-select framing and a start/busy/done handshake.
// One shift register serves both directions: the outgoing bit leaves one end
// while the sampled MISO bit enters the other end.
module spi_master_xcvr #(
  parameter int DATA_W    = 8,
  parameter int DIV_W     = 8,
  parameter int LSB_FIRST = 1
) (
  input  logic              clk_i,
  input  logic              clr_i,
  input  logic [DATA_W-1:0] tx_data_i,
  input  logic              write_i,
  input  logic              cpol_i,
  input  logic              cpha_i,
  input  logic [DIV_W-1:0]  div_i,
  input  logic              miso_i,
  output logic              sclk_o,
  output logic              mosi_o,
  output logic              cs_n_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] rx_data_o
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LEAD  = 2'd1;
  localparam logic [1:0] ST_XFER  = 2'd2;
  localparam logic [1:0] ST_TRAIL = 2'd3;

  // Edge counter runs 0 .. 2*DATA_W-1 across the data phase.
  localparam int               EDGE_W    = $clog2(2 * DATA_W);
  localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(2 * DATA_W - 1);

  logic [1:0]        state_q, state_d;
  logic [DIV_W-1:0]  cnt_q, cnt_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic              cpol_q, cpol_d;
  logic              cpha_q, cpha_d;
  logic [EDGE_W-1:0] edge_q, edge_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              sclk_q, sclk_d;
  logic              mosi_q, mosi_d;
  logic              cs_n_q, cs_n_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] rx_q, rx_d;

  logic tick;
  logic leading;

  // Bit that leaves the shift register next, depending on bit order.
  function automatic logic out_bit(input logic [DATA_W-1:0] s);
    if (LSB_FIRST != 0) begin
      return s[0];
    end
    return s[DATA_W-1];
  endfunction

  // Advance the shift register by one bit, inserting the sampled MISO value
  // at the end opposite to the one being transmitted from.
  function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] s,
                                                 input logic b);
    if (LSB_FIRST != 0) begin
      return {b, s[DATA_W-1:1]};
    end
    return {s[DATA_W-2:0], b};
  endfunction

  // Half-period tick: counter runs 0..div_q inclusive, never past div_q,
  // so the all-ones divider cannot overflow the counter width.
  assign tick    = (cnt_q == div_q);
  // Even edge index means SCLK is moving away from its idle level.
  assign leading = ~edge_q[0];

  // Next-state logic for the transfer sequencer and the SPI pins.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    cpol_d  = cpol_q;
    cpha_d  = cpha_q;
    edge_d  = edge_q;
    shreg_d = shreg_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    cs_n_d  = cs_n_q;
    done_d  = 1'b0;
    rx_d    = rx_q;

    if (state_q != ST_IDLE) begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        sclk_d = cpol_i;
        cs_n_d = 1'b1;
        if (write_i) begin
          state_d = ST_LEAD;
          cs_n_d  = 1'b0;
          cnt_d   = '0;
          edge_d  = '0;
          shreg_d = tx_data_i;
          div_d   = div_i;
          cpol_d  = cpol_i;
          cpha_d  = cpha_i;
          // CPHA=0 slaves sample on the very first edge, so the first bit
          // must already be on the line before SCLK moves.
          if (!cpha_i) begin
            mosi_d = out_bit(tx_data_i);
          end
        end
      end

      ST_LEAD: begin
        if (tick) begin
          state_d = ST_XFER;
        end
      end

      ST_XFER: begin
        if (tick) begin
          sclk_d = ~sclk_q;
          edge_d = edge_q + 1'b1;
          if (leading) begin
            if (!cpha_q) begin
              shreg_d = shift_in(shreg_q, miso_i);
            end else begin
              mosi_d = out_bit(shreg_q);
            end
          end else begin
            if (!cpha_q) begin
              // Last trailing edge: no further bit to present.
              if (edge_q != LAST_EDGE) begin
                mosi_d = out_bit(shreg_q);
              end
            end else begin
              shreg_d = shift_in(shreg_q, miso_i);
            end
          end
          if (edge_q == LAST_EDGE) begin
            state_d = ST_TRAIL;
            edge_d  = '0;
          end
        end
      end

      ST_TRAIL: begin
        if (tick) begin
          state_d = ST_IDLE;
          cs_n_d  = 1'b1;
          done_d  = 1'b1;
          rx_d    = shreg_q;
          mosi_d  = 1'b0;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers with synchronous clear; SCLK parks at the live CPOL.
  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      div_q   <= '0;
      cpol_q  <= 1'b0;
      cpha_q  <= 1'b0;
      edge_q  <= '0;
      shreg_q <= '0;
      sclk_q  <= cpol_i;
      mosi_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      done_q  <= 1'b0;
      rx_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      cpol_q  <= cpol_d;
      cpha_q  <= cpha_d;
      edge_q  <= edge_d;
      shreg_q <= shreg_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      cs_n_q  <= cs_n_d;
      done_q  <= done_d;
      rx_q    <= rx_d;
    end
  end

  assign sclk_o    = sclk_q;
  assign mosi_o    = mosi_q;
  assign cs_n_o    = cs_n_q;
  assign busy_o    = (state_q != ST_IDLE);
  assign done_o    = done_q;
  assign rx_data_o = rx_q;

endmodule

// File: doc/spi_master_xcvr.md
Name: spi_master_xcvr

Overview:
- Parametrised full-duplex SPI master. Successor to the fixed 8-bit sender/receiver pair.
- Adds the following over that pair:
  - configurable word width;
  - all four SPI modes (CPOL/CPHA);
  - a programmable SCLK divider and bit order;
  - chip-select generation;
  - a start/busy/done handshake.
- Sits between the host-side register logic and the SPI pins.
- Sends and receives simultaneously through one shift register.

Parameters:
- DATA_W, 8: bits per transfer (2..32).
- DIV_W, 8: width of the DIV port.
- LSB_FIRST, 1: 1 shifts bit 0 first; 0 shifts bit DATA_W-1 first.

Ports:
- CLK  in  1  system clock; all logic on its rising edge.
- CLR  in  1  synchronous, active-high reset.
- TX_DATA  in  DATA_W  word to transmit; captured on accepted WRITE.
- WRITE  in  1  start request; accepted only when BUSY=0.
- CPOL  in  1  SCLK idle level; captured on accept.
- CPHA  in  1  0: sample on leading edge; 1: sample on trailing edge. Captured on accept.
- DIV  in  DIV_W  SCLK half-period = DIV+1 CLK cycles; captured on accept.
- MISO  in  1  serial data from slave.
- SCLK  out  1  SPI clock, registered.
- MOSI  out  1  serial data to slave, registered.
- CS_N  out  1  active-low chip select, registered.
- BUSY  out  1  high while a transfer is in progress.
- DONE  out  1  one-cycle pulse at end of transfer.
- RX_DATA  out  DATA_W  last received word; holds until the next DONE.

Behaviour:
- Reset (CLR=1 at a rising edge), effective next cycle:
  - state IDLE;
  - CS_N=1, SCLK=CPOL (live input), MOSI=0, BUSY=0, DONE=0, RX_DATA=0;
  - divider and bit counters cleared.
- CLR mid-transfer aborts immediately. No DONE pulse; RX_DATA is cleared to 0.
- States: IDLE -> LEAD -> XFER -> TRAIL -> IDLE.
- Half-period tick: the divider counts 0..DIV_latched; tick when count==DIV_latched, then the counter wraps to 0. DIV=0 gives a tick every cycle.
- IDLE:
  - SCLK follows CPOL each cycle; CS_N=1.
  - WRITE=1 at an edge latches TX_DATA, CPOL, CPHA and DIV. Next cycle: LEAD, BUSY=1, CS_N=0.
  - If CPHA=0, MOSI is driven with the first bit on that same edge.
- LEAD: one half-period (CS setup). SCLK stays at idle level. The tick moves to XFER.
- XFER: 2*DATA_W half-periods. SCLK toggles on each tick.
  - Edges alternate leading (away from CPOL) and trailing.
  - CPHA=0: sample MISO on each leading edge. Drive the next MOSI bit on each trailing edge except the last.
  - CPHA=1: drive the MOSI bit on each leading edge. Sample MISO on each trailing edge.
  - After the 2*DATA_W-th edge, SCLK is back at CPOL. Move to TRAIL.
- TRAIL: one half-period (CS hold). On the tick:
  - CS_N=1, BUSY=0, DONE=1 for one cycle;
  - RX_DATA takes the assembled word;
  - MOSI=0; state IDLE.
- Bit order: LSB_FIRST=1 sends TX_DATA[0] first and places the first sampled bit at RX_DATA[0]. LSB_FIRST=0 is the mirror.
- Latency: accept at edge k. BUSY is high for exactly N=(2*DATA_W+2)*(DIV+1) cycles. DONE is asserted in the first cycle BUSY reads 0.
- WRITE while BUSY=1 is ignored: no queueing, latched config unchanged.
- WRITE in the DONE cycle is accepted: back-to-back transfer, CS_N high for exactly one cycle.
- CPOL/CPHA/DIV changes during a transfer have no effect until the next accept.
- DIV=max (all ones) gives half-period 2^DIV_W cycles. The counter must not overflow the width.

Test Plan:
- Mode 0, DIV=0, MISO tied to MOSI, TX=0xA5 -> RX_DATA=0xA5; BUSY high 18 cycles; 8 rising SCLK edges; DONE single pulse; CS_N low 18 cycles.
- Mode 3, DIV=2, slave model returns 0x3C, TX=0xC3 -> slave captures 0xC3, RX_DATA=0x3C; SCLK idle high; every SCLK level lasts 3 cycles; BUSY 54 cycles.
- Modes 1 and 2, DIV=1, loopback TX=0x81 -> RX_DATA=0x81; MISO sampled only on the trailing (mode 1) or leading (mode 2) edges, checked by a bench-side MISO glitch between edges.
- WRITE pulsed again mid-transfer with TX=0xFF -> ignored; first transfer completes unchanged; one DONE only.
- CLR asserted halfway through a transfer -> next cycle CS_N=1, SCLK=CPOL, BUSY=0, RX_DATA=0, no DONE. A fresh WRITE with 0x5A then completes correctly.
- LSB_FIRST=0, DATA_W=16 instance, TX=0x8001, back-to-back WRITE of 0x1234 in the DONE cycle -> MOSI MSB-first stream; RX_DATA 0x8001 then 0x1234; CS_N high exactly 1 cycle between the words.
